// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer and the ALU top it drives:
// opcodes, FSM states and the one-hot mux select constants.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT   = 3'd2,
    OP_XOR   = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MULT  = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  localparam logic [2:0] IN_SEL_RESET   = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_PERSIST = 3'b001;
  localparam logic [6:0] OUT_SEL_NONE   = 7'b000_0000;

  // CLEAR has no ALU output lane, so it selects nothing.
  function automatic logic [6:0] out_sel_of(input op_e op);
    logic [6:0] sel;
    sel = OUT_SEL_NONE;
    if (op != OP_CLEAR) sel = 7'b000_0001 << op;
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra
// bit so full and empty are distinguishable when the indices match.
module sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign w_wr    = i_wr_en && (!o_full || i_rd_en);
  assign w_rd    = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands and sequences each one through load/persist on an
// external ALU, holding the accumulator and the response handshake.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_on,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_operand,
  output logic [2:0]       o_alu_in_sel,
  output logic [WIDTH-1:0] o_alu_num1,
  output logic [WIDTH-1:0] o_alu_num2,
  output logic [6:0]       o_alu_out_sel,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_ovf,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_sticky_err
);
  state_e             r_state, w_state_nxt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_operand, r_acc, r_rsp_data;
  logic               r_rsp_err, r_sticky;
  logic               w_full, w_empty, w_pop, w_push, w_ovf_hit;
  logic [WIDTH+2:0]   w_head;

  assign w_pop       = (r_state == ST_IDLE) && i_on && !w_empty;
  assign o_cmd_ready = !w_full || w_pop;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_ovf_hit   = (r_op == OP_MULT) && i_alu_ovf;

  sync_fifo #(.W(WIDTH + 3), .DEPTH(DEPTH)) u_cmd_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (w_push),
    .i_wr_data({i_cmd_op, i_cmd_operand}),
    .i_rd_en  (w_pop),
    .o_rd_data(w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_pop) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_RESPOND;
      ST_RESPOND: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_alu_in_sel  = IN_SEL_PERSIST;
    o_alu_out_sel = OUT_SEL_NONE;
    o_alu_num1    = r_acc;
    o_alu_num2    = '0;
    if (r_state == ST_ISSUE) begin
      o_alu_in_sel  = (r_op == OP_CLEAR) ? IN_SEL_RESET : IN_SEL_LOAD;
      o_alu_out_sel = out_sel_of(r_op);
      o_alu_num2    = r_operand;
    end else if (r_state == ST_CAPTURE) begin
      o_alu_out_sel = out_sel_of(r_op);
      o_alu_num2    = r_operand;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_AND;
      r_operand  <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_op      <= op_e'(w_head[WIDTH+2:WIDTH]);
        r_operand <= w_head[WIDTH-1:0];
      end
      if (r_state == ST_CAPTURE) begin
        if (r_op == OP_CLEAR) begin
          r_acc      <= '0;
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b0;
          r_sticky   <= 1'b0;
        end else begin
          r_acc      <= i_alu_result;
          r_rsp_data <= i_alu_result;
          r_rsp_err  <= w_ovf_hit;
          if (w_ovf_hit) r_sticky <= 1'b1;
        end
      end
    end
  end

  assign o_rsp_valid  = (r_state == ST_RESPOND);
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_err    = r_rsp_err;
  assign o_sticky_err = r_sticky;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered ALU model on the
// mux/lane interface.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst, on, cmd_valid, cmd_ready, alu_ovf, rsp_valid, rsp_ready, rsp_err, sticky_err;
  logic [2:0] cmd_op, alu_in_sel;
  logic [6:0] alu_out_sel;
  logic [7:0] cmd_operand, alu_num1, alu_num2, alu_result, rsp_data;
  logic [7:0] m_a, m_b;
  logic [15:0] m_prod;
  int checks = 0;
  int errors = 0;

  alu_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_on(on),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_operand(cmd_operand),
    .o_alu_in_sel(alu_in_sel), .o_alu_num1(alu_num1), .o_alu_num2(alu_num2),
    .o_alu_out_sel(alu_out_sel), .i_alu_result(alu_result), .i_alu_ovf(alu_ovf),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_sticky_err(sticky_err)
  );

  always #5 clk = ~clk;

  // ALU model: operands latched on load, cleared on reset, held on persist.
  always @(posedge clk) begin
    if (alu_in_sel == 3'b100) begin
      m_a <= 8'h00; m_b <= 8'h00;
    end else if (alu_in_sel == 3'b010) begin
      m_a <= alu_num1; m_b <= alu_num2;
    end
  end

  always_comb begin
    m_prod     = m_a * m_b;
    alu_result = 8'h00;
    alu_ovf    = 1'b0;
    case (alu_out_sel)
      7'h01: alu_result = m_a & m_b;
      7'h02: alu_result = m_a | m_b;
      7'h04: alu_result = ~m_a;
      7'h08: alu_result = m_a ^ m_b;
      7'h10: alu_result = m_a + m_b;
      7'h20: alu_result = m_a - m_b;
      7'h40: begin alu_result = m_prod[7:0]; alu_ovf = |m_prod[15:8]; end
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] opnd);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, check it, and let it be consumed (rsp_ready=1).
  task automatic expect_rsp(input string tag, input logic [7:0] d, input logic e);
    int n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, d});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    tick();
  endtask

  task automatic count_idle(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin tick(); if (rsp_valid) seen++; end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b1; on = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_err", {30'd0, rsp_err, sticky_err}, 32'd0);
    chk("rst_in_sel", {29'd0, alu_in_sel}, 32'd1);
    chk("rst_out_sel", {25'd0, alu_out_sel}, 32'd0);
    chk("rst_nums", {16'd0, alu_num1, alu_num2}, 32'd0);
    rst = 1'b0; on = 1'b1; rsp_ready = 1'b1;

    // CLEAR, ADD 5 with cycle-by-cycle pipeline checks, ADD 3
    push(3'd7, 8'h00);
    expect_rsp("clear0", 8'h00, 1'b0);
    push(3'd4, 8'h05);
    chk("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("issue_in_sel", {29'd0, alu_in_sel}, 32'd2);
    chk("issue_out_sel", {25'd0, alu_out_sel}, 32'h10);
    chk("issue_nums", {16'd0, alu_num1, alu_num2}, 32'h0005);
    tick();
    chk("cap_in_sel", {29'd0, alu_in_sel}, 32'd1);
    chk("cap_out_sel", {25'd0, alu_out_sel}, 32'h10);
    chk("cap_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("lat_e3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_out_sel", {25'd0, alu_out_sel}, 32'd0);
    expect_rsp("add5", 8'h05, 1'b0);
    push(3'd4, 8'h03);
    expect_rsp("add3", 8'h08, 1'b0);

    // Overflow and sticky error, plus the remaining ops
    push(3'd7, 8'h00); expect_rsp("clear1", 8'h00, 1'b0);
    push(3'd4, 8'h20); expect_rsp("add20", 8'h20, 1'b0);
    push(3'd6, 8'h10); expect_rsp("mult_ovf", 8'h00, 1'b1);
    chk("sticky_set", {31'd0, sticky_err}, 32'd1);
    push(3'd4, 8'h01); expect_rsp("add1_after", 8'h01, 1'b0);
    chk("sticky_hold", {31'd0, sticky_err}, 32'd1);
    push(3'd7, 8'h00); expect_rsp("clear2", 8'h00, 1'b0);
    chk("sticky_clr", {31'd0, sticky_err}, 32'd0);
    push(3'd5, 8'h03); expect_rsp("sub_wrap", 8'hFD, 1'b0);
    push(3'd3, 8'hFF); expect_rsp("xor", 8'h02, 1'b0);
    push(3'd0, 8'h0F); expect_rsp("and", 8'h02, 1'b0);
    push(3'd1, 8'hF0); expect_rsp("or", 8'hF2, 1'b0);
    push(3'd2, 8'h00); expect_rsp("not", 8'h0D, 1'b0);
    push(3'd6, 8'h03); expect_rsp("mult_ok", 8'h27, 1'b0);
    push(3'd7, 8'h00); expect_rsp("clear3", 8'h00, 1'b0);

    // Back-pressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    push(3'd4, 8'h07);
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {24'd0, rsp_data}, 32'h07);
      chk("hold_in_sel", {29'd0, alu_in_sel}, 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("hold_release", {31'd0, rsp_valid}, 32'd0);

    // Fill the FIFO while off, then push into the full FIFO on the pop edge
    on = 1'b0;
    push(3'd4, 8'h01); push(3'd4, 8'h02); push(3'd4, 8'h03); push(3'd4, 8'h04);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_operand = 8'h05; on = 1'b1;
    #1;
    chk("full_pop_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("full_after_pushpop", {31'd0, cmd_ready}, 32'd0);
    expect_rsp("q1", 8'h08, 1'b0);
    expect_rsp("q2", 8'h0A, 1'b0);
    expect_rsp("q3", 8'h0D, 1'b0);
    expect_rsp("q4", 8'h11, 1'b0);
    expect_rsp("q5", 8'h16, 1'b0);

    // on dropped mid-transaction: current one completes, no new pop
    on = 1'b0;
    push(3'd4, 8'h01); push(3'd4, 8'h01);
    on = 1'b1; tick(); on = 1'b0;
    expect_rsp("off_mid", 8'h17, 1'b0);
    count_idle("off_no_pop", 10);
    on = 1'b1;
    expect_rsp("off_resume", 8'h18, 1'b0);

    // Reset during CAPTURE with two commands still queued
    on = 1'b0;
    push(3'd4, 8'h01); push(3'd4, 8'h01); push(3'd4, 8'h01);
    on = 1'b1; tick(); tick();
    chk("pre_rst_cap_sel", {22'd0, alu_in_sel, alu_out_sel}, {22'd0, 3'b001, 7'h10});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mrst_data", {24'd0, rsp_data}, 32'd0);
    chk("mrst_sels", {22'd0, alu_in_sel, alu_out_sel}, {22'd0, 3'b001, 7'h00});
    chk("mrst_acc", {24'd0, alu_num1}, 32'd0);
    count_idle("mrst_no_rsp", 15);
    push(3'd4, 8'h09);
    expect_rsp("post_rst", 8'h09, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
